// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - ID/EX operand stage: registers decode fields, forwards operands, detects load-use hazards
module alu_operand_stage #(
   parameter int XLEN = 32,
   parameter int RAW  = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            stall,
   input  logic            id_valid,
   output logic            id_ready,
   input  logic [RAW-1:0]  id_rs1_addr,
   input  logic [RAW-1:0]  id_rs2_addr,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic            id_uses_rs2,
   input  logic [XLEN-1:0] id_imm,
   input  logic            id_use_imm,
   input  logic [3:0]      id_alu_control,
   input  logic [RAW-1:0]  id_rd_addr,
   input  logic            id_reg_write,
   input  logic            id_is_load,
   input  logic            exm_reg_write,
   input  logic [RAW-1:0]  exm_rd_addr,
   input  logic [XLEN-1:0] exm_result,
   input  logic            wb_reg_write,
   input  logic [RAW-1:0]  wb_rd_addr,
   input  logic [XLEN-1:0] wb_data,
   output logic            ex_valid,
   output logic [XLEN-1:0] ex_a,
   output logic [XLEN-1:0] ex_b,
   output logic [XLEN-1:0] ex_store_data,
   output logic [3:0]      ex_alu_control,
   output logic [RAW-1:0]  ex_rd_addr,
   output logic            ex_reg_write,
   output logic            ex_is_load,
   output logic            load_use_stall
);

   logic [RAW-1:0]  rs1_addr_q, rs2_addr_q;
   logic [XLEN-1:0] rs1_data_q, rs2_data_q, imm_q;
   logic            use_imm_q;
   logic [XLEN-1:0] fwd_rs1, fwd_rs2;

   // EX/MEM is the younger producer, so it takes priority over MEM/WB.
   function automatic logic [XLEN-1:0] fwd(
      input logic [RAW-1:0]  addr,
      input logic [XLEN-1:0] latched,
      input logic            m_we,
      input logic [RAW-1:0]  m_rd,
      input logic [XLEN-1:0] m_val,
      input logic            w_we,
      input logic [RAW-1:0]  w_rd,
      input logic [XLEN-1:0] w_val
   );
      if (addr == '0)
         return '0;
      else if (m_we && m_rd == addr)
         return m_val;
      else if (w_we && w_rd == addr)
         return w_val;
      else
         return latched;
   endfunction

   always_comb begin
      fwd_rs1 = fwd(rs1_addr_q, rs1_data_q, exm_reg_write, exm_rd_addr, exm_result,
                    wb_reg_write, wb_rd_addr, wb_data);
      fwd_rs2 = fwd(rs2_addr_q, rs2_data_q, exm_reg_write, exm_rd_addr, exm_result,
                    wb_reg_write, wb_rd_addr, wb_data);
   end

   assign ex_a          = fwd_rs1;
   assign ex_store_data = fwd_rs2;
   assign ex_b          = use_imm_q ? imm_q : fwd_rs2;

   assign load_use_stall = id_valid && ex_valid && ex_is_load && (ex_rd_addr != '0) &&
                           ((ex_rd_addr == id_rs1_addr) ||
                            (id_uses_rs2 && ex_rd_addr == id_rs2_addr));
   assign id_ready = !stall && !load_use_stall;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_valid       <= 1'b0;
         rs1_addr_q     <= '0;
         rs2_addr_q     <= '0;
         rs1_data_q     <= '0;
         rs2_data_q     <= '0;
         imm_q          <= '0;
         use_imm_q      <= 1'b0;
         ex_alu_control <= '0;
         ex_rd_addr     <= '0;
         ex_reg_write   <= 1'b0;
         ex_is_load     <= 1'b0;
      end else if (flush) begin
         ex_valid     <= 1'b0;
         ex_reg_write <= 1'b0;
         ex_is_load   <= 1'b0;
      end else if (stall) begin
         // Refresh operands so a writeback retiring during the stall is not lost.
         rs1_data_q <= fwd_rs1;
         rs2_data_q <= fwd_rs2;
      end else if (load_use_stall || !id_valid) begin
         ex_valid     <= 1'b0;
         ex_reg_write <= 1'b0;
         ex_is_load   <= 1'b0;
      end else begin
         ex_valid       <= 1'b1;
         rs1_addr_q     <= id_rs1_addr;
         rs2_addr_q     <= id_rs2_addr;
         rs1_data_q     <= id_rs1_data;
         rs2_data_q     <= id_rs2_data;
         imm_q          <= id_imm;
         use_imm_q      <= id_use_imm;
         ex_alu_control <= id_alu_control;
         ex_rd_addr     <= id_rd_addr;
         ex_reg_write   <= id_reg_write;
         ex_is_load     <= id_is_load;
      end
   end

endmodule
